// File: rtl/vdp_super_res_writer_pkg.sv
// Shared types and constants for the super-res write path.
// Used by the writer top, its byte FIFO and the VRAM write-channel interface.
package super_res_write_pkg;

   localparam int WR_ADDR_W   = 20;
   localparam int VRAM_WORD_W = 18;

   typedef struct packed {
      logic [WR_ADDR_W-1:0] addr;
      logic [7:0]           data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      GATHER,
      REQ
   } wr_state_t;

   // One-hot byte enable for a byte lane within a 32-bit VRAM word
   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

   // Place a pixel byte on its lane of a 32-bit word, other lanes zero
   function automatic logic [31:0] lane_data(input logic [1:0] lane, input logic [7:0] data);
      return {24'd0, data} << {lane, 3'b000};
   endfunction

endpackage

// File: rtl/vdp_super_res_writer_if.sv
// VRAM arbiter write channel used by the super-res writer.
// master = writer side (drives request), slave = arbiter side (drives ack).
interface vdp_super_res_writer_if;
   import super_res_write_pkg::*;

   logic                   vram_wr_req;
   logic [VRAM_WORD_W-1:0] vram_wr_addr;
   logic [31:0]            vram_wr_data;
   logic [3:0]             vram_wr_be;
   logic                   vram_wr_ack;

   modport master (
      output vram_wr_req,
      output vram_wr_addr,
      output vram_wr_data,
      output vram_wr_be,
      input  vram_wr_ack
   );

   modport slave (
      input  vram_wr_req,
      input  vram_wr_addr,
      input  vram_wr_data,
      input  vram_wr_be,
      output vram_wr_ack
   );

endinterface

// File: rtl/vdp_super_res_writer_fifo.sv
// super_res_wr_fifo: small synchronous FIFO of {address, byte} entries.
// Flush wins over push and pop; full/empty are registered from the next count.
module super_res_wr_fifo
   import super_res_write_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        flush,
   input  wr_entry_t                   push_entry,
   output wr_entry_t                   head,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wr_entry_t        mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [CNT_W-1:0] count_next;

   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // Next occupancy, so full/empty can be registered alongside the count
   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else begin
         count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Pointers, count and the registered full/empty flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
         full  <= (count_next == CNT_W'(FIFO_DEPTH));
         empty <= (count_next == '0);
      end
   end

   // Entry storage; no reset needed since empty gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/vdp_super_res_writer.sv
// vdp_super_res_writer: buffers CPU pixel bytes and commits them to 32-bit VRAM
// while the display fetcher is not using the bus.
// Optional byte coalescing into one word write: define SUPER_RES_WRITE_COALESCE_EN.
module vdp_super_res_writer
   import super_res_write_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vdp_super,
   input  logic                  super_res_drawing,
   input  logic                  cpu_addr_load,
   input  logic [WR_ADDR_W-1:0]  cpu_addr,
   input  logic                  cpu_wr,
   input  logic [7:0]            cpu_data,
   input  logic                  overflow_clr,
   vdp_super_res_writer_if.master vram,
   output logic [WR_ADDR_W-1:0]  wr_pointer,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow
);

   wr_state_t                   state;
   logic                        req_q;
   logic [VRAM_WORD_W-1:0]      addr_q;
   logic [31:0]                 data_q;
   logic [3:0]                  be_q;
   wr_entry_t                   head;
   wr_entry_t                   push_entry;
   logic                        q_full;
   logic                        q_empty;
   logic [$clog2(FIFO_DEPTH):0] q_count;
   logic                        push;
   logic                        pop;
   logic                        drop;
   logic [WR_ADDR_W-1:0]        base_addr;
   logic [1:0]                  head_lane;
   logic [VRAM_WORD_W-1:0]      head_word;

   // A load in the same cycle as a write redirects that byte to the new address
   assign base_addr  = cpu_addr_load ? cpu_addr : wr_pointer;
   assign push       = cpu_wr && vdp_super && !q_full;
   assign drop       = cpu_wr && vdp_super && q_full;
   assign push_entry = '{addr: base_addr, data: cpu_data};
   assign head_lane  = head.addr[1:0];
   assign head_word  = head.addr[WR_ADDR_W-1:2];

`ifdef SUPER_RES_WRITE_COALESCE_EN
   logic head_mergeable;
   assign head_mergeable = !q_empty && vdp_super && (head_word == addr_q) && !be_q[head_lane];

   // Pop the first byte unconditionally, then keep popping while the head fits the word
   always_comb begin
      pop = 1'b0;
      if (state == GATHER) pop = (be_q == 4'b0000) || head_mergeable;
   end
`else
   // Exactly one byte leaves the FIFO per request
   always_comb begin
      pop = 1'b0;
      if (state == GATHER) pop = 1'b1;
   end
`endif

   super_res_wr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (!vdp_super),
      .push_entry (push_entry),
      .head       (head),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count)
   );

   // Auto-increment write pointer; only accepted writes advance it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_pointer <= '0;
      end else if (push) begin
         wr_pointer <= base_addr + WR_ADDR_W'(1);
      end else if (cpu_addr_load) begin
         wr_pointer <= cpu_addr;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

   // Write FSM: launch from IDLE only when the bus is free, form the word, hold until ack
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         be_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((q_count != '0) && !super_res_drawing && vdp_super) begin
                  state <= GATHER;
`ifdef SUPER_RES_WRITE_COALESCE_EN
                  be_q   <= '0;
                  data_q <= '0;
`endif
               end
            end
            GATHER: begin
`ifdef SUPER_RES_WRITE_COALESCE_EN
               if (be_q == 4'b0000) begin
                  addr_q <= head_word;
                  be_q   <= lane_be(head_lane);
                  data_q <= lane_data(head_lane, head.data);
               end else if (head_mergeable) begin
                  be_q   <= be_q | lane_be(head_lane);
                  data_q <= data_q | lane_data(head_lane, head.data);
                  if ((be_q | lane_be(head_lane)) == 4'b1111) begin
                     state <= REQ;
                     req_q <= 1'b1;
                  end
               end else begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
`else
               addr_q <= head_word;
               be_q   <= lane_be(head_lane);
               data_q <= lane_data(head_lane, head.data);
               state  <= REQ;
               req_q  <= 1'b1;
`endif
            end
            REQ: begin
               if (vram.vram_wr_ack) begin
                  state <= IDLE;
                  req_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign vram.vram_wr_req  = req_q;
   assign vram.vram_wr_addr = addr_q;
   assign vram.vram_wr_data = data_q;
   assign vram.vram_wr_be   = be_q;

   assign fifo_full  = q_full;
   assign fifo_empty = q_empty && (state == IDLE);

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Self-checking bench for vdp_super_res_writer.
// Expected VRAM requests come from a queue model of pending bytes, grouped into
// word writes (coalesced when SUPER_RES_WRITE_COALESCE_EN is defined).
module tb_vdp_super_res_writer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        vdp_super;
   logic        super_res_drawing;
   logic        cpu_addr_load;
   logic [19:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_data;
   logic        overflow_clr;
   logic [19:0] wr_pointer;
   logic        fifo_empty;
   logic        fifo_full;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [19:0] addr;
      logic [7:0]  data;
   } ent_t;

   typedef struct {
      logic [17:0] word;
      logic [31:0] data;
      logic [3:0]  be;
   } req_t;

   ent_t        pend[$];
   req_t        exp_q[$];
   logic [19:0] model_ptr = 20'd0;
   bit          model_ovf = 1'b0;

   vdp_super_res_writer_if vram_bus();

   vdp_super_res_writer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .vdp_super         (vdp_super),
      .super_res_drawing (super_res_drawing),
      .cpu_addr_load     (cpu_addr_load),
      .cpu_addr          (cpu_addr),
      .cpu_wr            (cpu_wr),
      .cpu_data          (cpu_data),
      .overflow_clr      (overflow_clr),
      .vram              (vram_bus),
      .wr_pointer        (wr_pointer),
      .fifo_empty        (fifo_empty),
      .fifo_full         (fifo_full),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Turn pending bytes into the word writes the arbiter should see, in order
   task automatic build_expected();
      ent_t e;
      req_t r;
      while (pend.size() > 0) begin
         e = pend.pop_front();
         r.word = e.addr[19:2];
         r.be   = 4'b0001 << e.addr[1:0];
         r.data = {24'd0, e.data} << (8 * int'(e.addr[1:0]));
`ifdef SUPER_RES_WRITE_COALESCE_EN
         while (pend.size() > 0 && pend[0].addr[19:2] == r.word && r.be[pend[0].addr[1:0]] == 1'b0) begin
            e = pend.pop_front();
            r.be   = r.be | (4'b0001 << e.addr[1:0]);
            r.data = r.data | ({24'd0, e.data} << (8 * int'(e.addr[1:0])));
         end
`endif
         exp_q.push_back(r);
      end
   endtask

   task automatic load_addr(input logic [19:0] a);
      cpu_addr_load = 1'b1;
      cpu_addr      = a;
      tick();
      cpu_addr_load = 1'b0;
      model_ptr     = a;
   endtask

   // One CPU write strobe (optionally with a same-cycle address load), tracked by the model
   task automatic write_byte(input logic [7:0] d, input bit with_load, input logic [19:0] a);
      logic [19:0] base;
      cpu_wr        = 1'b1;
      cpu_data      = d;
      cpu_addr_load = with_load;
      cpu_addr      = a;
      base = with_load ? a : model_ptr;
      if (!vdp_super) begin
         if (with_load) model_ptr = a;
      end else if (pend.size() < DEPTH) begin
         pend.push_back('{base, d});
         model_ptr = base + 20'd1;
      end else begin
         model_ptr = base;
         model_ovf = 1'b1;
      end
      tick();
      cpu_wr        = 1'b0;
      cpu_addr_load = 1'b0;
   endtask

   // Act as the arbiter: accept every expected request with a random ack delay
   task automatic service_requests(input string name, output int n_seen);
      req_t r;
      int   waited;
      int   lat;
      bit   extra;
      n_seen = 0;
      build_expected();
      while (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         waited = 0;
         while (vram_bus.vram_wr_req !== 1'b1 && waited < 40) begin
            tick();
            waited++;
         end
         checks++;
         if (vram_bus.vram_wr_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_timeout: req=%b required=1", name, vram_bus.vram_wr_req);
            exp_q.delete();
            break;
         end
         n_seen++;
         checks++;
         if (vram_bus.vram_wr_addr !== r.word || vram_bus.vram_wr_data !== r.data || vram_bus.vram_wr_be !== r.be) begin
            errors++;
            $display("[TB] FAIL %s req_fields: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                     name, vram_bus.vram_wr_addr, vram_bus.vram_wr_data, vram_bus.vram_wr_be, r.word, r.data, r.be);
         end
         lat = int'($urandom_range(0, 3));
         repeat (lat) begin
            tick();
            checks++;
            if (vram_bus.vram_wr_req !== 1'b1 || vram_bus.vram_wr_addr !== r.word ||
                vram_bus.vram_wr_data !== r.data || vram_bus.vram_wr_be !== r.be) begin
               errors++;
               $display("[TB] FAIL %s req_hold: got req=%b addr=%h data=%h be=%b, required req=1 addr=%h data=%h be=%b",
                        name, vram_bus.vram_wr_req, vram_bus.vram_wr_addr, vram_bus.vram_wr_data, vram_bus.vram_wr_be,
                        r.word, r.data, r.be);
            end
         end
         vram_bus.vram_wr_ack = 1'b1;
         tick();
         vram_bus.vram_wr_ack = 1'b0;
         checks++;
         if (vram_bus.vram_wr_req !== 1'b0 || fifo_empty !== (exp_q.size() == 0)) begin
            errors++;
            $display("[TB] FAIL %s after_ack: got req=%b fifo_empty=%b, required req=0 fifo_empty=%b",
                     name, vram_bus.vram_wr_req, fifo_empty, exp_q.size() == 0);
         end
      end
      extra = 1'b0;
      repeat (12) begin
         tick();
         if (vram_bus.vram_wr_req === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("[TB] FAIL %s extra_req: got an unexpected request, required none", name);
      end
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      vdp_super         = 1'b1;
      super_res_drawing = 1'b0;
      cpu_addr_load     = 1'b0;
      cpu_addr          = 20'd0;
      cpu_wr            = 1'b0;
      cpu_data          = 8'd0;
      overflow_clr      = 1'b0;
      vram_bus.vram_wr_ack = 1'b0;
      repeat (3) tick();
      checks++;
      if ({vram_bus.vram_wr_req, vram_bus.vram_wr_addr, vram_bus.vram_wr_data, vram_bus.vram_wr_be} !== 55'd0) begin
         errors++;
         $display("[TB] FAIL reset_bus: got req=%b addr=%h data=%h be=%b, required all zero",
                  vram_bus.vram_wr_req, vram_bus.vram_wr_addr, vram_bus.vram_wr_data, vram_bus.vram_wr_be);
      end
      checks++;
      if (wr_pointer !== 20'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_status: got ptr=%h empty=%b full=%b ovf=%b, required ptr=0 empty=1 full=0 ovf=0",
                  wr_pointer, fifo_empty, fifo_full, overflow);
      end
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if (vram_bus.vram_wr_req !== 1'b0 || fifo_empty !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_idle: got req=%b empty=%b, required req=0 empty=1", vram_bus.vram_wr_req, fifo_empty);
      end
   endtask

   task automatic test_single_write();
      super_res_drawing = 1'b0;
      load_addr(20'h00102);
      write_byte(8'hAA, 1'b0, 20'd0);
      pend.delete();
      checks++;
      if (wr_pointer !== 20'h00103 || vram_bus.vram_wr_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_n: got ptr=%h req=%b, required ptr=00103 req=0", wr_pointer, vram_bus.vram_wr_req);
      end
      tick();
      checks++;
      if (vram_bus.vram_wr_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_n1: got req=%b, required 0", vram_bus.vram_wr_req);
      end
`ifdef SUPER_RES_WRITE_COALESCE_EN
      tick();
`endif
      tick();
      checks++;
      if (vram_bus.vram_wr_req !== 1'b1 || vram_bus.vram_wr_addr !== 18'h00040 ||
          vram_bus.vram_wr_be !== 4'b0100 || vram_bus.vram_wr_data !== 32'h00AA0000 || fifo_empty !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_req: got req=%b addr=%h be=%b data=%h empty=%b, required req=1 addr=00040 be=0100 data=00aa0000 empty=0",
                  vram_bus.vram_wr_req, vram_bus.vram_wr_addr, vram_bus.vram_wr_be, vram_bus.vram_wr_data, fifo_empty);
      end
      tick();
      tick();
      vram_bus.vram_wr_ack = 1'b1;
      tick();
      vram_bus.vram_wr_ack = 1'b0;
      checks++;
      if (vram_bus.vram_wr_req !== 1'b0 || fifo_empty !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_ack: got req=%b empty=%b, required req=0 empty=1", vram_bus.vram_wr_req, fifo_empty);
      end
   endtask

   task automatic test_drawing_block();
      int  n;
      bit  seen;
      super_res_drawing = 1'b1;
      load_addr(20'h00301);
      for (int i = 0; i < 3; i++) write_byte(8'($urandom), 1'b0, 20'd0);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (vram_bus.vram_wr_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || fifo_empty !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drawing_hold: got req_seen=%b empty=%b, required req_seen=0 empty=0", seen, fifo_empty);
      end
      super_res_drawing = 1'b0;
      service_requests("drawing", n);
   endtask

   task automatic test_overflow();
      int          n;
      logic [19:0] base;
      super_res_drawing = 1'b1;
      base = 20'($urandom);
      write_byte(8'($urandom), 1'b1, base);
      for (int i = 1; i < 10; i++) write_byte(8'($urandom), 1'b0, 20'd0);
      checks++;
      if (fifo_full !== 1'b1 || overflow !== model_ovf || wr_pointer !== model_ptr) begin
         errors++;
         $display("[TB] FAIL overflow_set: got full=%b ovf=%b ptr=%h, required full=1 ovf=%b ptr=%h",
                  fifo_full, overflow, wr_pointer, model_ovf, model_ptr);
      end
      overflow_clr = 1'b1;
      write_byte(8'h5A, 1'b0, 20'd0);
      overflow_clr = 1'b0;
      checks++;
      if (overflow !== 1'b1 || wr_pointer !== model_ptr) begin
         errors++;
         $display("[TB] FAIL overflow_set_wins: got ovf=%b ptr=%h, required ovf=1 ptr=%h", overflow, wr_pointer, model_ptr);
      end
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      model_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overflow_clear: got ovf=%b, required 0", overflow);
      end
      super_res_drawing = 1'b0;
      service_requests("overflow", n);
      checks++;
      if (fifo_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overflow_drain_full: got full=%b, required 0", fifo_full);
      end
   endtask

   task automatic test_wrap();
      int n;
      super_res_drawing = 1'b1;
      load_addr(20'hFFFFF);
      write_byte(8'hC3, 1'b0, 20'd0);
      write_byte(8'h3C, 1'b0, 20'd0);
      checks++;
      if (wr_pointer !== 20'h00001) begin
         errors++;
         $display("[TB] FAIL wrap_ptr: got ptr=%h, required 00001", wr_pointer);
      end
      super_res_drawing = 1'b0;
      service_requests("wrap", n);
   endtask

   task automatic test_coalesce();
      int n;
      int want;
      super_res_drawing = 1'b1;
      load_addr(20'h00200);
      for (int i = 0; i < 4; i++) write_byte(8'h11 * (i + 1), 1'b0, 20'd0);
      super_res_drawing = 1'b0;
      service_requests("coalesce", n);
`ifdef SUPER_RES_WRITE_COALESCE_EN
      want = 1;
`else
      want = 4;
`endif
      checks++;
      if (n != want) begin
         errors++;
         $display("[TB] FAIL coalesce_count: got %0d requests, required %0d", n, want);
      end
   endtask

   task automatic test_flush();
      int waited;
      bit seen;
      super_res_drawing = 1'b1;
      for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i), 1'b1, 20'h01000 + 20'(4 * i));
      super_res_drawing = 1'b0;
      waited = 0;
      while (vram_bus.vram_wr_req !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (vram_bus.vram_wr_req !== 1'b1 || vram_bus.vram_wr_addr !== 18'h00400 ||
          vram_bus.vram_wr_be !== 4'b0001 || vram_bus.vram_wr_data !== 32'h00000010) begin
         errors++;
         $display("[TB] FAIL flush_first_req: got req=%b addr=%h be=%b data=%h, required req=1 addr=00400 be=0001 data=00000010",
                  vram_bus.vram_wr_req, vram_bus.vram_wr_addr, vram_bus.vram_wr_be, vram_bus.vram_wr_data);
      end
      vdp_super = 1'b0;
      repeat (3) tick();
      checks++;
      if (vram_bus.vram_wr_req !== 1'b1 || vram_bus.vram_wr_addr !== 18'h00400 || fifo_empty !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_req_hold: got req=%b addr=%h empty=%b, required req=1 addr=00400 empty=0",
                  vram_bus.vram_wr_req, vram_bus.vram_wr_addr, fifo_empty);
      end
      vram_bus.vram_wr_ack = 1'b1;
      tick();
      vram_bus.vram_wr_ack = 1'b0;
      seen = (vram_bus.vram_wr_req === 1'b1);
      repeat (15) begin
         tick();
         if (vram_bus.vram_wr_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_drained: got req_seen=%b empty=%b full=%b, required req_seen=0 empty=1 full=0",
                  seen, fifo_empty, fifo_full);
      end
      write_byte(8'h99, 1'b0, 20'd0);
      checks++;
      if (wr_pointer !== model_ptr || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_wr_ignored: got ptr=%h ovf=%b, required ptr=%h ovf=0", wr_pointer, overflow, model_ptr);
      end
      pend.delete();
      vdp_super = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (vram_bus.vram_wr_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || fifo_empty !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_reenable: got req_seen=%b empty=%b, required req_seen=0 empty=1", seen, fifo_empty);
      end
   endtask

   task automatic test_reset_mid_req();
      int waited;
      super_res_drawing = 1'b1;
      write_byte(8'h77, 1'b1, 20'h00ABC);
      super_res_drawing = 1'b0;
      waited = 0;
      while (vram_bus.vram_wr_req !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (vram_bus.vram_wr_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_req: got req=%b, required 1", vram_bus.vram_wr_req);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (vram_bus.vram_wr_req !== 1'b0 || wr_pointer !== 20'd0 || fifo_empty !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_drop: got req=%b ptr=%h empty=%b, required req=0 ptr=0 empty=1",
                  vram_bus.vram_wr_req, wr_pointer, fifo_empty);
      end
      tick();
      reset = 1'b0;
      pend.delete();
      model_ptr = 20'd0;
      model_ovf = 1'b0;
      repeat (3) tick();
      checks++;
      if (vram_bus.vram_wr_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_after: got req=%b, required 0", vram_bus.vram_wr_req);
      end
   endtask

   task automatic test_random();
      int          n;
      int          cnt;
      int          kind;
      logic [19:0] last_addr;
      logic [19:0] a;
      last_addr = 20'h00000;
      for (int round = 0; round < 6; round++) begin
         super_res_drawing = 1'b1;
         cnt = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < cnt; i++) begin
            kind = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? last_addr : 20'($urandom);
            if (kind == 0) begin
               write_byte(8'($urandom), 1'b1, a);
               last_addr = a;
            end else if (kind == 1) begin
               load_addr(a);
               last_addr = a;
               write_byte(8'($urandom), 1'b0, 20'd0);
            end else begin
               write_byte(8'($urandom), 1'b0, 20'd0);
            end
         end
         checks++;
         if (wr_pointer !== model_ptr) begin
            errors++;
            $display("[TB] FAIL random_ptr round %0d: got ptr=%h, required %h", round, wr_pointer, model_ptr);
         end
         super_res_drawing = 1'b0;
         service_requests("random", n);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_drawing_block();
      test_overflow();
      test_wrap();
      test_coalesce();
      test_flush();
      test_reset_mid_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_super_res_writer.md
# vdp_super_res_writer

Write-side companion to the super-res display fetcher: accepts CPU pixel bytes for the super-res framebuffer, buffers them in a small FIFO, and commits them to 32-bit VRAM. Writes are issued only while the display fetcher does not own the bus (`super_res_drawing` low). The block sits between the VDP CPU port decode and the VRAM arbiter's write channel.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: entries in the byte FIFO; power of two, 4..32.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `vdp_super`  in  1  super mode enable; low acts as a synchronous flush.
- `super_res_drawing`  in  1  high while the display fetcher owns VRAM; no new request may launch while high.
- `cpu_addr_load`  in  1  one-cycle strobe; loads the write pointer.
- `cpu_addr`  in  20  byte address loaded by `cpu_addr_load`. Word address is [19:2]; byte lane is [1:0].
- `cpu_wr`  in  1  one-cycle strobe; enqueues `cpu_data` at the write pointer.
- `cpu_data`  in  8  pixel byte (palette index).
- `overflow_clr`  in  1  clears `overflow`.
- `vram_wr_req`  out  1  write request; held until ack.
- `vram_wr_addr`  out  18  VRAM word address.
- `vram_wr_data`  out  32  write data, lane-aligned.
- `vram_wr_be`  out  4  byte enables.
- `vram_wr_ack`  in  1  one-cycle completion from the arbiter.
- `wr_pointer`  out  20  current auto-increment pointer.
- `fifo_empty`  out  1  no pending bytes and no request in flight.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky; set when `cpu_wr` is dropped.

## Operation
- Pointer:
  - `cpu_addr_load` sets the pointer to `cpu_addr`.
  - Each accepted `cpu_wr` writes {pointer, data} into the FIFO, then pointer <= pointer+1, modulo 2^20 (0xFFFFF wraps to 0).
  - `cpu_addr_load` and `cpu_wr` in the same cycle: the byte goes to `cpu_addr`, and the pointer becomes `cpu_addr`+1.
- Full handling:
  - `cpu_wr` while `fifo_full` (registered) is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
  - `overflow_clr` clears `overflow`. If `overflow_clr` and a drop occur in the same cycle, set wins.
- FSM states: IDLE, GATHER, REQ.
  - IDLE -> GATHER when the FIFO is non-empty and `super_res_drawing`==0 and `vdp_super`==1. GATHER pops the head and forms `vram_wr_addr`=entry[19:2], lane=entry[1:0], `vram_wr_be`=one-hot(lane), and data at bits [8*lane+7:8*lane] with all other bits 0.
  - GATHER -> REQ next cycle; `vram_wr_req` is asserted in REQ.
  - REQ: `vram_wr_req` is held with stable addr/data/be until `vram_wr_ack`, regardless of `super_res_drawing`. On ack, return to IDLE and drop `vram_wr_req` the same edge.
- `vdp_super` low:
  - FIFO is flushed every cycle and `cpu_wr` is ignored; `overflow` is not set.
  - An in-flight REQ completes normally on ack; the FSM then stays in IDLE.
- Reset mid-request: `vram_wr_req` drops immediately. The arbiter must tolerate an abandoned request.

## Timing
- Reset values:
  - `vram_wr_req`=0, `vram_wr_addr`=0, `vram_wr_data`=0, `vram_wr_be`=0.
  - `wr_pointer`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, FSM=IDLE.
- Latency, bus free: `cpu_wr` at edge N -> entry valid N+1 -> GATHER N+1 -> `vram_wr_req` high N+2.
- Throughput: one byte per 3 cycles plus arbiter ack latency (non-coalesced).
- `super_res_drawing` is sampled only in IDLE. Its rise during GATHER does not abort the request.
- `fifo_empty` goes high the cycle after the ack of the last entry.

## Configuration
- `SUPER_RES_WRITE_COALESCE_EN` defined:
  - GATHER continues popping one entry per cycle while the head's [19:2] equals the gathered word and its lane's `be` bit is still clear.
  - Each merged byte ORs into `data`/`be`; at most 4 pops per request.
  - GATHER exits to REQ when the next entry mismatches, the FIFO is empty, or `be`==4'b1111.
- Undefined: exactly one byte per request, as described in Operation.

## Structure
- Shared package `super_res_write_pkg`:
  - `wr_entry_t` struct {addr[19:0], data[7:0]};
  - `wr_state_t` enum {IDLE, GATHER, REQ};
  - constants `WR_ADDR_W`=20 and `VRAM_WORD_W`=18.
- Sub-module `super_res_wr_fifo`: synchronous FIFO of `wr_entry_t` with push/pop/flush, registered full/empty, and a count. Depth is taken from `FIFO_DEPTH`.

## Test plan
- Load addr 0x00102, write 0xAA, bus free, ack after 2 cycles -> req at N+2 with addr 0x00040, be 4'b0100, data 0x00AA0000; `wr_pointer`=0x00103.
- Hold `super_res_drawing`=1, write 3 bytes -> no req; drop drawing -> writes in order; `fifo_empty` high after the 3rd ack.
- With `FIFO_DEPTH`=8, no ack, write 10 bytes -> 2 dropped and `overflow`=1; `overflow_clr` -> 0.
- Load 0xFFFFF, write 2 bytes -> second byte at addr 0x00000, word 0, be 4'b0001.
- With COALESCE_EN, load 0x00200 and write 4 bytes (bus blocked) then free -> single req addr 0x00080, be 4'b1111. Without COALESCE_EN -> 4 reqs.
- Deassert `vdp_super` during REQ with 3 queued -> current req completes on ack; no further reqs; `fifo_empty`=1.
